// File: rtl/uart_lock_rx.sv
// uart_lock_rx: 8N1 UART receiver with single-byte open/close command decode
// and an optional auto-relock timer driving the registered lock_open level.
//
// Output handshake: rx_valid and frame_err are single-cycle pulses with no
// backpressure (there is no ready). rx_byte is stable from the rx_valid cycle
// until the next good frame, and lock_open reacts on the edge that ends the
// rx_valid cycle.
module uart_lock_rx #(
    parameter int         CLK_FREQ          = 50_000_000,
    parameter int         BAUD              = 9600,
    parameter logic [7:0] OPEN_CMD          = 8'h4F,
    parameter logic [7:0] CLOSE_CMD         = 8'h43,
    parameter int         AUTO_CLOSE_CYCLES = 500_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_pin,
    output logic       lock_open,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       frame_err
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    // Guard against a degenerate half-bit of zero when CLKS_PER_BIT is 1.
    localparam int HALF_BIT     = (CLKS_PER_BIT / 2 > 0) ? CLKS_PER_BIT / 2 : 1;
    localparam int BAUD_W       = $clog2(CLKS_PER_BIT + 1);
    localparam logic [BAUD_W-1:0] BIT_END  = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] HALF_END = BAUD_W'(HALF_BIT - 1);

    // Relock counter sized for its largest value; width stays legal when disabled.
    localparam int RC_MAX = (AUTO_CLOSE_CYCLES > 0) ? AUTO_CLOSE_CYCLES : 1;
    localparam int RC_W   = $clog2(RC_MAX + 1);
    localparam logic [RC_W-1:0] RC_END = RC_W'(RC_MAX - 1);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_STOP      = 3'd3;
    localparam logic [2:0] ST_WAIT_HIGH = 3'd4;

    logic              rx_meta;
    logic              rx_s;
    logic [2:0]        state;
    logic [BAUD_W-1:0] baud_cnt;
    logic [2:0]        bit_idx;
    logic [7:0]        shift_reg;
    logic [RC_W-1:0]   relock_cnt;

    // Two-flop synchroniser; resets to the idle-high line level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_pin;
            rx_s    <= rx_meta;
        end
    end

    // Receive FSM: mid-bit sampling from the start edge, stop-bit check, and
    // a wait-for-high after a framing error so a held-low line cannot retrigger.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            rx_byte   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state    <= ST_START;
                        baud_cnt <= '0;
                    end
                end
                ST_START: begin
                    if (baud_cnt == HALF_END) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        // A line back high at mid-start is a glitch, not a frame.
                        state    <= rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (baud_cnt == BIT_END) begin
                        baud_cnt  <= '0;
                        shift_reg <= {rx_s, shift_reg[7:1]};
                        if (bit_idx == 3'd7) begin
                            state <= ST_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (baud_cnt == BIT_END) begin
                        baud_cnt <= '0;
                        if (rx_s) begin
                            rx_byte  <= shift_reg;
                            rx_valid <= 1'b1;
                            state    <= ST_IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= ST_WAIT_HIGH;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                ST_WAIT_HIGH: begin
                    if (rx_s) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Command decode and auto-relock; a decoded command takes priority over
    // the timer, so an OPEN landing on the relock cycle keeps the lock open.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_open  <= 1'b0;
            relock_cnt <= '0;
        end else if (rx_valid && (rx_byte == OPEN_CMD)) begin
            lock_open  <= 1'b1;
            relock_cnt <= '0;
        end else if (rx_valid && (rx_byte == CLOSE_CMD)) begin
            lock_open  <= 1'b0;
            relock_cnt <= '0;
        end else if ((AUTO_CLOSE_CYCLES != 0) && lock_open) begin
            if (relock_cnt == RC_END) begin
                lock_open  <= 1'b0;
                relock_cnt <= '0;
            end else begin
                relock_cnt <= relock_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_lock_rx.sv
// tb_uart_lock_rx: directed and randomized frames against a behavioural model
// of the command rules and relock deadline, kept as event timestamps.
module tb_uart_lock_rx;

  localparam int         CLK_FREQ  = 1_000_000;
  localparam int         BAUD      = 100_000;
  localparam int         BIT_CLKS  = CLK_FREQ / BAUD;
  localparam int         AUTO      = 1000;
  localparam logic [7:0] OPEN_CMD  = 8'h4F;
  localparam logic [7:0] CLOSE_CMD = 8'h43;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_pin = 1'b1;
  logic       lock_open;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       frame_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int s_cyc = 0;

  // monitor capture
  logic [7:0] val_q[$];
  int         val_t[$];
  int         err_t[$];
  int         lock_t[$];
  logic       lock_v[$];
  logic       lock_prev = 1'b0;

  // reference model state
  logic [7:0] exp_q[$];
  int         exp_lt[$];
  logic       exp_lv[$];
  logic       lock_m = 1'b0;
  int         close_at = 0;
  logic [7:0] exp_byte = 8'h00;

  uart_lock_rx #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD(BAUD),
    .OPEN_CMD(OPEN_CMD),
    .CLOSE_CMD(CLOSE_CMD),
    .AUTO_CLOSE_CYCLES(AUTO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx_pin(rx_pin),
    .lock_open(lock_open),
    .rx_byte(rx_byte),
    .rx_valid(rx_valid),
    .frame_err(frame_err)
  );

  // clock and cycle count
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // monitor on the falling edge
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid === 1'b1) begin
        val_q.push_back(rx_byte);
        val_t.push_back(cyc);
      end
      if (frame_err === 1'b1) err_t.push_back(cyc);
      if (lock_open !== lock_prev) begin
        lock_t.push_back(cyc);
        lock_v.push_back(lock_open);
      end
    end
    lock_prev = lock_open;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model: byte b decoded with rx_valid at cycle t acts on edge t+1.
  task automatic model_byte(input logic [7:0] b, input int t);
    int edge_c;
    edge_c = t + 1;
    if (lock_m && close_at < edge_c) begin
      exp_lt.push_back(close_at); exp_lv.push_back(1'b0); lock_m = 1'b0;
    end
    if (b == OPEN_CMD) begin
      if (!lock_m) begin exp_lt.push_back(edge_c); exp_lv.push_back(1'b1); end
      lock_m = 1'b1;
      close_at = edge_c + AUTO;
    end else if (lock_m && (b == CLOSE_CMD || close_at == edge_c)) begin
      exp_lt.push_back(edge_c); exp_lv.push_back(1'b0); lock_m = 1'b0;
    end
  endtask

  task automatic model_flush(input int now);
    if (lock_m && close_at <= now) begin
      exp_lt.push_back(close_at); exp_lv.push_back(1'b0); lock_m = 1'b0;
    end
  endtask

  // driver: one 8N1 frame, stop bit level selectable; returns at end of stop bit
  task automatic send_frame(input logic [7:0] b, input logic stop_ok);
    @(posedge clk); #1 rx_pin = 1'b0; s_cyc = cyc;
    for (int i = 0; i < 8; i++) begin
      repeat (BIT_CLKS) @(posedge clk); #1 rx_pin = b[i];
    end
    repeat (BIT_CLKS) @(posedge clk); #1 rx_pin = stop_ok;
    repeat (BIT_CLKS - 1) @(posedge clk);
  endtask

  // scoreboard for the frame just sent
  task automatic process_frame(input logic [7:0] b, input logic stop_ok);
    logic [7:0] v;
    int t;
    #1;
    if (stop_ok) begin
      chk("valid_count", val_q.size(), 1);
      chk("err_count_good", err_t.size(), 0);
      if (val_q.size() > 0 && exp_q.size() > 0) begin
        v = val_q.pop_front(); t = val_t.pop_front();
        chk("rx_byte_pulse", v, exp_q.pop_front());
        chk("valid_latency", (t - s_cyc >= 96) && (t - s_cyc <= 98), 1);
        model_byte(b, t);
        exp_byte = b;
      end
    end else begin
      chk("valid_count_bad", val_q.size(), 0);
      chk("err_count", err_t.size(), 1);
      if (err_t.size() > 0) begin
        t = err_t.pop_front();
        chk("err_latency", (t - s_cyc >= 96) && (t - s_cyc <= 98), 1);
      end
    end
    val_q.delete(); val_t.delete(); err_t.delete();
    chk("rx_byte_hold", rx_byte, exp_byte);
  endtask

  task automatic check_lock();
    @(negedge clk); #1;
    model_flush(cyc);
    chk("lock_events", lock_t.size(), exp_lt.size());
    while (lock_t.size() > 0 && exp_lt.size() > 0) begin
      chk("lock_time", lock_t.pop_front(), exp_lt.pop_front());
      chk("lock_value", lock_v.pop_front(), exp_lv.pop_front());
    end
    lock_t.delete(); lock_v.delete(); exp_lt.delete(); exp_lv.delete();
    chk("lock_level", lock_open, lock_m);
  endtask

  task automatic good(input logic [7:0] b);
    exp_q.push_back(b);
    send_frame(b, 1'b1);
    process_frame(b, 1'b1);
  endtask

  task automatic bad(input logic [7:0] b);
    send_frame(b, 1'b0);
    process_frame(b, 1'b0);
    repeat (40) @(posedge clk); #1 rx_pin = 1'b1;
    repeat (20) @(posedge clk);
    #1 chk("err_no_retrigger", val_q.size() + err_t.size(), 0);
  endtask

  initial begin
    logic [7:0] rb;
    int sel;
    // reset state
    repeat (3) @(posedge clk); #1;
    chk("rst_lock", lock_open, 0);
    chk("rst_byte", rx_byte, 8'h00);
    chk("rst_valid", rx_valid, 0);
    chk("rst_err", frame_err, 0);
    rst = 1'b0;
    repeat (5) @(posedge clk);

    // open, then close back-to-back
    good(OPEN_CMD);
    good(CLOSE_CMD);
    check_lock();

    // ignored byte, then a short glitch
    good(8'h55);
    check_lock();
    @(posedge clk); #1 rx_pin = 1'b0;
    repeat (3) @(posedge clk); #1 rx_pin = 1'b1;
    repeat (120) @(posedge clk); #1;
    chk("glitch_quiet", val_q.size() + err_t.size(), 0);

    // framing error carrying CLOSE must not close or update rx_byte
    good(OPEN_CMD);
    good(8'h5A);
    bad(CLOSE_CMD);
    check_lock();
    good(CLOSE_CMD);
    check_lock();

    // auto-relock
    good(OPEN_CMD);
    repeat (1100) @(posedge clk);
    check_lock();

    // re-open part way through restarts the hold time
    good(OPEN_CMD);
    repeat (400) @(posedge clk);
    good(OPEN_CMD);
    check_lock();
    repeat (1100) @(posedge clk);
    check_lock();

    // randomized frames and gaps
    for (int n = 0; n < 14; n++) begin
      sel = $urandom_range(0, 5);
      rb = 8'($urandom_range(0, 255));
      repeat ($urandom_range(0, 300)) @(posedge clk);
      case (sel)
        0, 1: good(OPEN_CMD);
        2: good(CLOSE_CMD);
        5: bad(rb);
        default: good(rb);
      endcase
      check_lock();
    end

    // reset in the middle of data bit 4 while open
    good(OPEN_CMD);
    check_lock();
    fork
      send_frame(OPEN_CMD, 1'b1);
      begin
        repeat (46) @(posedge clk); #1 rst = 1'b1;
        #2;
        chk("mid_rst_lock", lock_open, 0);
        chk("mid_rst_byte", rx_byte, 8'h00);
        chk("mid_rst_valid", rx_valid, 0);
        chk("mid_rst_err", frame_err, 0);
      end
    join
    repeat (3) @(posedge clk); #1 rst = 1'b0;
    lock_m = 1'b0; exp_byte = 8'h00;
    lock_t.delete(); lock_v.delete(); exp_lt.delete(); exp_lv.delete();
    repeat (20) @(posedge clk); #1;
    chk("post_rst_quiet", val_q.size() + err_t.size(), 0);
    chk("post_rst_lock", lock_open, 0);
    good(OPEN_CMD);
    check_lock();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_lock_rx.md
# uart_lock_rx

UART receive and command-decode front end that drives the lock position request for the servo/buzzer stage. It deserialises 8N1 frames from the RX pin, decodes single-byte open/close commands, and holds a registered `lock_open` level that downstream logic uses as its position select. An optional auto-relock timer closes the lock after a programmable hold time.

## Interface

- `CLK_FREQ`, default 50_000_000: system clock frequency in Hz.
- `BAUD`, default 9600: line rate; `CLKS_PER_BIT = CLK_FREQ / BAUD` (integer division).
- `OPEN_CMD`, default 8'h4F ('O'): byte that opens the lock.
- `CLOSE_CMD`, default 8'h43 ('C'): byte that closes the lock.
- `AUTO_CLOSE_CYCLES`, default 500_000_000: hold time before auto-relock; 0 disables auto-relock.
- `clk`  input  1  system clock; all logic on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `rx_pin`  input  1  asynchronous UART line, idle high.
- `lock_open`  output  1  registered lock request: 1 = open, 0 = closed.
- `rx_byte`  output  8  last correctly framed byte; holds its value between frames.
- `rx_valid`  output  1  one-cycle pulse when `rx_byte` updates.
- `frame_err`  output  1  one-cycle pulse when a stop bit samples low.

## Operation

- Reset values: `lock_open=0`, `rx_byte=8'h00`, `rx_valid=0`, `frame_err=0`. Synchroniser flops reset to 1. The FSM resets to IDLE and all counters reset to 0.
- `rx_pin` passes through a 2-flop synchroniser. Every decision uses the synchronised signal `rx_s`.
- RX FSM:
  - **IDLE**: on `rx_s==0`, go to START and clear the baud counter.
  - **START**: count `CLKS_PER_BIT/2` cycles, then sample.
    - `rx_s==0`: go to DATA with bit index 0.
    - `rx_s==1`: treat as a glitch and return to IDLE. No pulse.
  - **DATA**: count `CLKS_PER_BIT` cycles per bit and sample at the end of each period. Bits shift in LSB first. Move to STOP after bit index 7.
  - **STOP**: count `CLKS_PER_BIT` cycles, then sample.
    - `rx_s==1`: load `rx_byte` from the shift register, pulse `rx_valid`, go to IDLE.
    - `rx_s==0`: pulse `frame_err`, leave `rx_byte` unchanged, go to WAIT_HIGH.
  - **WAIT_HIGH**: stay until `rx_s==1`, then go to IDLE. This blocks re-triggering on a break or stuck-low line.
- Command decode is evaluated only on the `rx_valid` cycle:
  - `rx_byte==OPEN_CMD`: set `lock_open=1` and load the relock counter with 0.
  - `rx_byte==CLOSE_CMD`: set `lock_open=0` and clear the relock counter.
  - Any other byte: ignored. `lock_open` and the counter are unchanged.
- Auto-relock applies when `AUTO_CLOSE_CYCLES != 0` and `lock_open==1`:
  - The counter increments every cycle.
  - On reaching `AUTO_CLOSE_CYCLES-1`, `lock_open` clears and the counter clears.
  - A repeated OPEN while already open restarts the count from 0.
- Counter widths are derived with `$clog2` of their maximum value plus 1. No counter wraps in legal operation.

## Timing

- The decoder sees the command at the rising edge ending the cycle in which `rx_valid=1`. Therefore `lock_open` changes exactly 1 cycle after the `rx_valid` pulse.
- `rx_valid`/`frame_err` assert `2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT` cycles after the `rx_pin` falling edge, ±1 cycle for synchroniser phase. Each is high for exactly 1 cycle.
- Back-to-back frames:
  - A start bit arriving immediately after the stop-bit sample is accepted, because IDLE is entered on the cycle after the sample.
  - There is no buffering; each byte is decoded on its own `rx_valid`.
- Auto-relock coincides with a decoded OPEN in the same cycle: OPEN wins, `lock_open` stays 1 and the counter restarts.
- Auto-relock coincides with a decoded CLOSE in the same cycle: `lock_open=0`.
- Reset asserted mid-frame: the frame is aborted immediately, with no `rx_valid` or `frame_err`. All outputs return to reset values while `rst` is high.
- After reset deassertion, a line already low is treated as a start bit only after the synchroniser propagates it (2 cycles).

## Test plan

All scenarios use `CLK_FREQ=1_000_000`, `BAUD=100_000` (`CLKS_PER_BIT=10`), `AUTO_CLOSE_CYCLES=1000`.

- **Open command**: send 0x4F 8N1 → `rx_valid` pulses once ~97 cycles after the start edge with `rx_byte=0x4F`; `lock_open=1` on the next cycle.
- **Open then close**: send 0x4F, then 0x43 back-to-back → two `rx_valid` pulses, `lock_open` goes 1 then 0; `frame_err` never asserts.
- **Ignored byte and glitch**:
  - Send 0x55 → `rx_valid` pulses with `rx_byte=0x55`, `lock_open` unchanged.
  - Drive a 3-cycle low glitch on `rx_pin` → no `rx_valid`.
- **Framing error**: send 0x4F with the stop bit low, then hold the line low 50 cycles → single `frame_err` pulse, `rx_byte` keeps its old value, `lock_open` unchanged. The next valid frame after the line returns high decodes normally.
- **Auto-relock**:
  - Open, wait → `lock_open` falls exactly 1000 cycles after it rose.
  - Open, re-send 0x4F at cycle 600 → closure occurs 1000 cycles after the second rise.
- **Reset mid-frame**: assert `rst` during data bit 4 of 0x4F with `lock_open=1` → `lock_open=0` asynchronously, no `rx_valid`; the next full 0x4F frame after release opens normally.
